// File: rtl/keypad_scan_if.sv
// Keypad scanner port bundle: pin-side row/column lines plus the decoded
// key event outputs. The master side is the scanner, the slave side is the
// keypad/user logic.
interface keypad_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) ();
  localparam int CODE_W = $clog2(ROWS * COLS);

  logic [COLS-1:0]   key_in;
  logic [ROWS-1:0]   key_out;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_release;
  logic              key_held;
  logic              multi_key;

  modport master (
    input  key_in,
    output key_out, key_code, key_valid, key_release, key_held, multi_key
  );

  modport slave (
    output key_in,
    input  key_out, key_code, key_valid, key_release, key_held, multi_key
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Self-timed ROWS x COLS matrix keypad scanner.
// A divider paces one row slot per SCAN_DIV cycles; columns are sampled at
// the end of each slot and folded into a per-frame result (none / single /
// multi). A frame result must repeat DEBOUNCE_SCANS times to be accepted.
// Accepted single keys produce key_valid, accepted "no key" after a press
// produces key_release. Optional auto-repeat is enabled with the macro
// KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);
  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int STB_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [STB_W-1:0]  STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [CODE_W-1:0] COLS_C   = CODE_W'(COLS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_e;
  typedef enum logic {ST_IDLE, ST_PRESSED} state_e;

  // Timing and scan state
  logic [DIV_W-1:0]  div_q, div_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [CODE_W-1:0] acc_code_q, acc_code_d;

  // Debounce state
  res_e              prev_res_q, prev_res_d;
  logic [CODE_W-1:0] prev_code_q, prev_code_d;
  logic [STB_W-1:0]  stable_cnt_q, stable_cnt_d;

  // Event FSM and registered outputs
  state_e            state_q, state_d;
  logic [ROWS-1:0]   key_out_q, key_out_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_release_q, key_release_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;

`ifdef KEYPAD_REPEAT_EN
  logic [31:0]       rpt_cnt_q, rpt_cnt_d;
  logic              rpt_first_q, rpt_first_d;
  logic [31:0]       rpt_next;
  logic [31:0]       rpt_limit;
`else
  // Repeat timing parameters have no effect when auto-repeat is compiled out.
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_unused
  end
`endif

  // Combinational scan helpers
  logic [COLS-1:0]   col_pressed;
  logic [1:0]        row_cnt_c;
  logic [COL_W-1:0]  row_first_c;
  logic [CODE_W-1:0] row_code_c;
  logic [2:0]        sum_c;
  logic [1:0]        frame_cnt_c;
  logic [CODE_W-1:0] frame_code_c;
  res_e              frame_res_c;
  logic [CODE_W-1:0] res_code_c;
  logic              tick_c;
  logic              frame_end_c;
  logic              same_c;
  logic [STB_W-1:0]  stable_nxt_c;
  logic              stable_c;

  // Columns are active-low; convert to a pressed mask
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col_pressed[gi] = ~kp.key_in[gi];
  end

  // Per-row count (saturating at 2) and lowest pressed column
  always_comb begin
    row_cnt_c   = 2'd0;
    row_first_c = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_pressed[c]) begin
        row_first_c = COL_W'(c);
        if (row_cnt_c != 2'd2) row_cnt_c = row_cnt_c + 2'd1;
      end
    end
  end

  // Merge this row into the frame accumulator and classify the frame
  always_comb begin
    tick_c       = (div_q == DIV_LAST);
    frame_end_c  = tick_c && (row_q == ROW_LAST);
    row_code_c   = CODE_W'(row_q) * COLS_C + CODE_W'(row_first_c);
    sum_c        = {1'b0, acc_cnt_q} + {1'b0, row_cnt_c};
    frame_cnt_c  = (sum_c > 3'd2) ? 2'd2 : sum_c[1:0];
    frame_code_c = (acc_cnt_q == 2'd0) ? row_code_c : acc_code_q;
    case (frame_cnt_c)
      2'd0:    frame_res_c = RES_NONE;
      2'd1:    frame_res_c = RES_SINGLE;
      default: frame_res_c = RES_MULTI;
    endcase
    res_code_c   = (frame_res_c == RES_SINGLE) ? frame_code_c : '0;
    same_c       = (frame_res_c == prev_res_q) && (res_code_c == prev_code_q);
    if (!same_c)                    stable_nxt_c = STB_W'(1);
    else if (stable_cnt_q == STB_MAX) stable_nxt_c = STB_MAX;
    else                            stable_nxt_c = stable_cnt_q + STB_W'(1);
    stable_c     = (stable_nxt_c == STB_MAX);
  end

  // Next-state logic for timer, accumulator, debounce and event FSM
  always_comb begin
    div_d         = tick_c ? '0 : div_q + DIV_W'(1);
    row_d         = row_q;
    acc_cnt_d     = acc_cnt_q;
    acc_code_d    = acc_code_q;
    prev_res_d    = prev_res_q;
    prev_code_d   = prev_code_q;
    stable_cnt_d  = stable_cnt_q;
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_held_d    = key_held_q;
    multi_key_d   = multi_key_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d     = rpt_cnt_q;
    rpt_first_d   = rpt_first_q;
    rpt_next      = rpt_cnt_q + 32'd1;
    rpt_limit     = rpt_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE);
`endif

    if (tick_c) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      if (frame_end_c) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = frame_cnt_c;
        acc_code_d = frame_code_c;
      end
    end

    if (frame_end_c) begin
      prev_res_d   = frame_res_c;
      prev_code_d  = res_code_c;
      stable_cnt_d = stable_nxt_c;
      if (stable_c) multi_key_d = (frame_res_c == RES_MULTI);

      case (state_q)
        ST_IDLE: begin
          if (stable_c && frame_res_c == RES_SINGLE) begin
            key_code_d  = frame_code_c;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d   = 32'd0;
            rpt_first_d = 1'b1;
`endif
          end
        end
        default: begin
          if (stable_c && frame_res_c == RES_NONE) begin
            key_release_d = 1'b1;
            key_held_d    = 1'b0;
            state_d       = ST_IDLE;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_d     = 32'd0;
            rpt_first_d   = 1'b1;
          end else if (stable_c && frame_res_c == RES_SINGLE &&
                       frame_code_c == key_code_q) begin
            if (rpt_next == rpt_limit) begin
              key_valid_d = 1'b1;
              rpt_cnt_d   = 32'd0;
              rpt_first_d = 1'b0;
            end else begin
              rpt_cnt_d   = rpt_next;
            end
          end else if (stable_c) begin
            rpt_cnt_d     = 32'd0;
            rpt_first_d   = 1'b1;
`endif
          end
        end
      endcase
    end

    key_out_d = ~(ROWS'(1) << row_d);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      row_q         <= '0;
      acc_cnt_q     <= 2'd0;
      acc_code_q    <= '0;
      prev_res_q    <= RES_NONE;
      prev_code_q   <= '0;
      stable_cnt_q  <= '0;
      state_q       <= ST_IDLE;
      key_out_q     <= ~ROWS'(1);
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      multi_key_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= 32'd0;
      rpt_first_q   <= 1'b1;
`endif
    end else begin
      div_q         <= div_d;
      row_q         <= row_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_code_q    <= acc_code_d;
      prev_res_q    <= prev_res_d;
      prev_code_q   <= prev_code_d;
      stable_cnt_q  <= stable_cnt_d;
      state_q       <= state_d;
      key_out_q     <= key_out_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_held_q    <= key_held_d;
      multi_key_q   <= multi_key_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_first_q   <= rpt_first_d;
`endif
    end
  end

  assign kp.key_out     = key_out_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_release = key_release_q;
  assign kp.key_held    = key_held_q;
  assign kp.multi_key   = multi_key_q;
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner with an integrated row-scan timer, frame-based debounce, and press/release event outputs. It replaces the separate scan-timing and 4x4 keypad blocks with one self-timed controller for any ROWS x COLS matrix. It reports a binary key code with a one-cycle valid strobe, and flags multi-key frames. It sits between the keypad pins and the user logic in the top level, and runs from the 100 MHz board clock.

## Interface
- ROWS, 4: number of driven rows (≥2).
- COLS, 4: number of sensed columns (≥2).
- SCAN_DIV, 100000: clk cycles per row slot (≥2); 1 ms at 100 MHz.
- DEBOUNCE_SCANS, 8: consecutive identical frames required to accept a result (≥1).
- REPEAT_DELAY, 500: frames before the first auto-repeat. Used only with the repeat macro.
- REPEAT_RATE, 100: frames between repeats. Used only with the repeat macro.
- CODE_W (localparam): $clog2(ROWS*COLS).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- key_in, in, COLS: column sense lines, externally pulled up; 0 means pressed.
- key_out, out, ROWS: row drive; exactly one bit low at a time.
- key_code, out, CODE_W: code of the last accepted key, computed as row*COLS + col.
- key_valid, out, 1: one-cycle pulse when key_code is updated or repeated.
- key_release, out, 1: one-cycle pulse when the accepted key is released.
- key_held, out, 1: high while in PRESSED.
- multi_key, out, 1: high while the debounced frame result is "multiple keys".

## Operation
- Divider counts 0..SCAN_DIV-1. A tick occurs on the cycle where the count equals SCAN_DIV-1.
- Row index advances on each tick and wraps ROWS-1 → 0. The row drive is key_out = ~(1 << row).
- Column sampling:
  - key_in is sampled on the tick, before the row advances, so each row gets SCAN_DIV-1 cycles to settle.
  - Per frame, the block accumulates the pressed-key count, saturating at 2, and the code of the first pressed key found (lowest row, then lowest col).
- Frame end is the tick where row == ROWS-1. The frame result is one of NONE, SINGLE(code) or MULTI.
- Debounce:
  - If the frame result equals the previous frame result, the stable counter increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the stable counter is set to 1.
  - A result is stable when the counter equals DEBOUNCE_SCANS.
- multi_key follows the stable result: it sets when MULTI becomes stable and clears when any other result becomes stable.
- FSM states: IDLE and PRESSED.
  - IDLE + stable SINGLE(c): key_code ← c, pulse key_valid, go to PRESSED.
  - IDLE + stable MULTI or NONE: stay in IDLE, no event.
  - PRESSED + stable NONE: pulse key_release, go to IDLE. key_code is retained.
  - PRESSED + stable SINGLE(c≠key_code) or MULTI: stay in PRESSED, no event. There is no rollover; a new key registers only after a full release.
- Events fire once per stable transition, not on every frame at saturation.

## Timing
- Reset values:
  - Divider 0, row 0, so key_out = {ROWS-1{1}},0 (4'b1110 for ROWS=4).
  - key_code 0; key_valid, key_release, key_held and multi_key all 0.
  - State IDLE; previous result NONE; stable counter 0.
- Reset mid-operation returns to the reset state on the next clk edge. A key held through reset generates a fresh key_valid after debounce.
- Frame length is ROWS*SCAN_DIV cycles.
- Press latency: key_valid is high on the cycle after the frame-end tick of the DEBOUNCE_SCANS-th consecutive identical SINGLE frame. Release latency is the same for NONE frames.
- key_held rises and falls in the same cycle as key_valid and key_release respectively.
- key_valid and key_release are never high in the same cycle.
- All outputs are registered.

## Configuration
- KEYPAD_REPEAT_EN defined: in PRESSED, while the stable result remains SINGLE(key_code), key_valid re-pulses after REPEAT_DELAY frame ends and then every REPEAT_RATE frame ends. The repeat counter clears on leaving PRESSED or on any other stable result.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per press, and the repeat logic is absent.

## Test plan
Bench parameters: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3, giving a 16-cycle frame.
- Reset → key_out=4'b1110, all outputs 0. Row cycles 1110→1101→1011→0111 every 4 cycles.
- Hold key row2/col1 clean → key_code=9 and a key_valid pulse on the cycle after the 3rd frame end. key_held=1, no further pulses. Release → key_release after 3 NONE frames.
- Toggle row2/col1 every other frame for 6 frames, then hold → no key_valid until 3 consecutive stable frames have passed.
- Hold row0/col0 and row3/col3 → multi_key=1 after 3 frames, no key_valid. Release one key → key_valid with code 15 (or 0) after 3 frames, multi_key=0.
- Key held, assert rst for 1 cycle mid-frame → outputs are at reset values next cycle. key_valid re-fires 3 frames after scanning resumes.
- With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold key 7 → key_valid at accept, then 5 frames later, then every 2 frames. Without the macro → exactly one pulse.
